// File: rtl/interp_stream_out.sv
// AXI-stream output stage for the nearest-neighbour interpolator: buffers strobed
// samples in a small FIFO feeding a registered output slot, frames packets with TLAST.
module interp_stream_out #(
    parameter int DW     = 28,
    parameter int LGFIFO = 4,
    parameter int PKTLEN = 1024
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ce,
    input  logic [DW-1:0]     i_data,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic [DW-1:0]     M_AXIS_TDATA,
    output logic              M_AXIS_TLAST,
    output logic [LGFIFO:0]   o_fill,
    output logic              o_overflow,
    input  logic              i_clear_overflow
);

    localparam int                MEMD     = (1 << LGFIFO) - 1;
    localparam logic [LGFIFO-1:0] LAST_IDX = LGFIFO'(MEMD - 1);
    localparam logic [LGFIFO:0]   CAP      = (LGFIFO+1)'(1 << LGFIFO);
    localparam logic [15:0]       PKT_MAX  = 16'(PKTLEN - 1);

    logic [DW:0]        r_mem [0:MEMD-1];
    logic [LGFIFO-1:0]  r_wptr, r_rptr, r_cnt;
    logic               r_valid, r_last, r_ovf;
    logic [DW-1:0]      r_data;
    logic [LGFIFO:0]    r_fill;
    logic [15:0]        r_pkt;

    logic               w_pop, w_full, w_accept, w_drop, w_load;
    logic               w_fifo_empty, w_fifo_rd, w_fifo_wr, w_bypass, w_last_in;
    logic [DW:0]        w_in, w_head;

    // The array holds one fewer entry than the total capacity, so pointers wrap at its end.
    function automatic logic [LGFIFO-1:0] ptr_inc(input logic [LGFIFO-1:0] p);
        return (p == LAST_IDX) ? {LGFIFO{1'b0}} : p + LGFIFO'(1);
    endfunction

    assign w_pop        = r_valid && M_AXIS_TREADY;
    assign w_full       = (r_fill == CAP);
    assign w_accept     = i_ce && (!w_full || w_pop);
    assign w_drop       = i_ce && w_full && !w_pop;
    assign w_load       = !r_valid || w_pop;
    assign w_fifo_empty = (r_cnt == {LGFIFO{1'b0}});
    assign w_fifo_rd    = w_load && !w_fifo_empty;
    // An empty FIFO lets an accepted sample skip straight into the output slot.
    assign w_bypass     = w_load && w_fifo_empty && w_accept;
    assign w_fifo_wr    = w_accept && !w_bypass;
    assign w_last_in    = (r_pkt == PKT_MAX);
    assign w_in         = {w_last_in, i_data};
    assign w_head       = r_mem[r_rptr];

    // Sample storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge i_clk) begin
        if (w_fifo_wr) begin
            r_mem[r_wptr] <= w_in;
        end
    end

    // Output slot, FIFO pointers, occupancy, packet framing and overflow flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_data  <= {DW{1'b0}};
            r_last  <= 1'b0;
            r_wptr  <= {LGFIFO{1'b0}};
            r_rptr  <= {LGFIFO{1'b0}};
            r_cnt   <= {LGFIFO{1'b0}};
            r_fill  <= {(LGFIFO+1){1'b0}};
            r_pkt   <= 16'd0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_load) begin
                if (w_fifo_rd) begin
                    {r_last, r_data} <= w_head;
                    r_valid          <= 1'b1;
                end else if (w_accept) begin
                    {r_last, r_data} <= w_in;
                    r_valid          <= 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
            end

            if (w_fifo_wr) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_fifo_rd) begin
                r_rptr <= ptr_inc(r_rptr);
            end

            case ({w_fifo_wr, w_fifo_rd})
                2'b10:   r_cnt <= r_cnt + LGFIFO'(1);
                2'b01:   r_cnt <= r_cnt - LGFIFO'(1);
                default: r_cnt <= r_cnt;
            endcase

            case ({w_accept, w_pop})
                2'b10:   r_fill <= r_fill + (LGFIFO+1)'(1);
                2'b01:   r_fill <= r_fill - (LGFIFO+1)'(1);
                default: r_fill <= r_fill;
            endcase

            if (w_accept) begin
                r_pkt <= w_last_in ? 16'd0 : r_pkt + 16'd1;
            end

            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_clear_overflow) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign M_AXIS_TVALID = r_valid;
    assign M_AXIS_TDATA  = r_data;
    assign M_AXIS_TLAST  = r_last;
    assign o_fill        = r_fill;
    assign o_overflow    = r_ovf;

endmodule

// File: tb/tb_interp_stream_out.sv
// Directed bench for interp_stream_out (LGFIFO=2, PKTLEN=3) with a reference
// occupancy/framing model and an expected-sample queue.
module tb_interp_stream_out;

    localparam int DW = 28;
    localparam int LG = 2;
    localparam int PL = 3;
    localparam int CAP = 1 << LG;

    logic            clk = 1'b0;
    logic            rst, ce, rdy, clr;
    logic [DW-1:0]   din;
    logic            tvalid, tlast, ovf;
    logic [DW-1:0]   tdata;
    logic [LG:0]     fill;

    int              checks = 0;
    int              errors = 0;
    int              m_fill, m_pkt;
    logic            m_ovf;
    logic [DW:0]     sb [$];
    logic            h_stall;
    logic [DW:0]     h_val;

    always #5 clk = ~clk;

    interp_stream_out #(.DW(DW), .LGFIFO(LG), .PKTLEN(PL)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_ce             (ce),
        .i_data           (din),
        .M_AXIS_TVALID    (tvalid),
        .M_AXIS_TREADY    (rdy),
        .M_AXIS_TDATA     (tdata),
        .M_AXIS_TLAST     (tlast),
        .o_fill           (fill),
        .o_overflow       (ovf),
        .i_clear_overflow (clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n, input logic c);
        rst = 1'b1; ce = c; din = 28'h5A5A5A5; rdy = 1'b1; clr = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("rst_tvalid", 32'(tvalid), 32'd0);
            chk("rst_tdata",  32'(tdata),  32'd0);
            chk("rst_tlast",  32'(tlast),  32'd0);
            chk("rst_fill",   32'(fill),   32'd0);
            chk("rst_ovf",    32'(ovf),    32'd0);
        end
        rst = 1'b0;
        m_fill = 0; m_pkt = 0; m_ovf = 1'b0; h_stall = 1'b0;
        sb.delete();
    endtask

    // One clock: drive inputs, check current outputs against the model, advance the model.
    task automatic cyc(input logic c, input logic [DW-1:0] d, input logic r, input logic cl);
        logic [DW:0] e;
        logic        pop, acc;
        ce = c; din = d; rdy = r; clr = cl;
        chk("tvalid", 32'(tvalid), 32'(m_fill != 0));
        chk("fill",   32'(fill),   32'(m_fill));
        chk("ovf",    32'(ovf),    32'(m_ovf));
        if (h_stall) begin
            chk("stall_tvalid", 32'(tvalid), 32'd1);
            chk("stall_hold",   32'({tlast, tdata}), 32'(h_val));
        end
        h_stall = tvalid && !r;
        h_val   = {tlast, tdata};
        pop = (m_fill != 0) && r;
        if (pop) begin
            e = sb.pop_front();
            chk("tdata", 32'(tdata), 32'(e[DW-1:0]));
            chk("tlast", 32'(tlast), 32'(e[DW]));
        end
        acc = c && ((m_fill != CAP) || pop);
        if (acc) begin
            sb.push_back({(m_pkt == PL - 1), d});
            m_pkt = (m_pkt == PL - 1) ? 0 : m_pkt + 1;
        end
        if (c && !acc) m_ovf = 1'b1;
        else if (cl)   m_ovf = 1'b0;
        m_fill = m_fill + int'(acc) - int'(pop);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] rpat;
        rst = 1'b1; ce = 1'b0; rdy = 1'b0; clr = 1'b0; din = '0;
        h_stall = 1'b0; h_val = '0; m_fill = 0; m_pkt = 0; m_ovf = 1'b0;

        // Reset held two cycles with strobes active.
        do_reset(2, 1'b1);

        // Streaming with the sink always ready.
        for (int i = 0; i < 6; i++) cyc(1'b1, 28'h10 + 28'(i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 28'h0, 1'b1, 1'b0);

        // Back-pressure: four fit, two are dropped.
        for (int i = 0; i < 6; i++) cyc(1'b1, 28'hA0 + 28'(i), 1'b0, 1'b0);
        chk("bp_fill_full", 32'(fill), 32'd4);
        chk("bp_overflow",  32'(ovf),  32'd1);
        cyc(1'b0, 28'h0, 1'b0, 1'b0);

        // Write-through at full, then clear racing a drop, then clear alone.
        cyc(1'b1, 28'hB0, 1'b1, 1'b0);
        chk("wt_fill", 32'(fill), 32'd4);
        cyc(1'b1, 28'hB1, 1'b0, 1'b1);
        chk("race_ovf", 32'(ovf), 32'd1);
        cyc(1'b0, 28'h0, 1'b0, 1'b1);
        chk("clear_ovf", 32'(ovf), 32'd0);

        // Drain with a toggling ready.
        rpat = 8'b1110_1101;
        for (int i = 0; i < 8; i++) cyc(1'b0, 28'h0, rpat[i], 1'b0);
        cyc(1'b0, 28'h0, 1'b1, 1'b0);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        // Mid-packet reset: buffered pre-reset samples must never appear.
        cyc(1'b1, 28'hC0, 1'b0, 1'b0);
        cyc(1'b1, 28'hC1, 1'b0, 1'b0);
        do_reset(1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 28'hD0 + 28'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 28'h0, 1'b1, 1'b0);
        chk("final_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
